// File: rtl/key_schedule_gen.sv
// key_schedule_gen: byte-serial AES-128/192/256 key expander streaming 128-bit round keys over valid/ready.
// Define KEYSCHED_REVERSE_EN to add a round-key store and reverse-order (dir=1) delivery.
module key_schedule_gen #(
  parameter int KEY_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 dir,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [127:0]         rk_data,
  output logic [3:0]           rk_idx,
  output logic                 rk_last
);
  localparam int NK = KEY_WIDTH / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [0:255][7:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_width
    $error("key_schedule_gen: KEY_WIDTH must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {IDLE, COPY, GEN, SUB, DRAIN} state_t;
  state_t state;
  logic [31:0] win [NK];
  logic [31:0] kbuf [3];
  logic [31:0] sub_w, src, t, new_w;
  logic [7:0] rcon, sb;
  logic [5:0] i;
  logic [2:0] m, m_nxt;
  logic [1:0] bc;
  logic [3:0] drain_idx;
  logic [127:0] drain_key;
  logic rev, completes, last_w, hold, wr_en, sub_nxt;

  always_comb begin
    src = m == 3'd0 ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
    sb = bc == 2'd0 ? src[31:24] : bc == 2'd1 ? src[23:16] : bc == 2'd2 ? src[15:8] : src[7:0];
    t = m == 3'd0 ? sub_w ^ {rcon, 24'h0} : (NK == 8 && m == 3'd4) ? sub_w : win[NK-1];
    new_w = state == COPY ? win[0] : win[0] ^ t;
    completes = i[1:0] == 2'd3;
    last_w = i == 6'(NW - 1);
    hold = completes && rk_valid && !rk_ready && !rev;
    wr_en = (state == COPY || (state == GEN && i != 6'(NW))) && !hold;
    m_nxt = m == 3'(NK - 1) ? 3'd0 : m + 3'd1;
    sub_nxt = m_nxt == 3'd0 || (NK == 8 && m_nxt == 3'd4);
    drain_idx = rk_valid ? rk_idx - 4'd1 : 4'(NR);
  end

`ifdef KEYSCHED_REVERSE_EN
  logic [127:0] store [NR+1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rev <= 1'b0;
    else if (state == IDLE && start) rev <= dir;
  always_ff @(posedge clk)
    if (wr_en && completes) store[i[5:2]] <= {kbuf[0], kbuf[1], kbuf[2], new_w};
  assign drain_key = store[drain_idx];
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign rev = 1'b0;
  assign drain_key = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      rk_valid <= 1'b0;
      rk_data <= '0;
      rk_idx <= '0;
      rk_last <= 1'b0;
      rcon <= 8'h01;
      i <= '0;
      m <= '0;
      bc <= '0;
      sub_w <= '0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
      for (int j = 0; j < 3; j++) kbuf[j] <= '0;
    end else begin
      if (rk_valid && rk_ready) begin
        rk_valid <= 1'b0;
        rk_last <= 1'b0;
        if (rk_last) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
      case (state)
        IDLE: if (start) begin
          state <= COPY;
          busy <= 1'b1;
          rcon <= 8'h01;
          i <= '0;
          m <= '0;
          bc <= '0;
          for (int j = 0; j < NK; j++) win[j] <= key_in[KEY_WIDTH-1-32*j -: 32];
        end
        SUB: begin
          sub_w <= {sub_w[23:0], SBOX[sb]};
          bc <= bc + 2'd1;
          if (bc == 2'd3) state <= GEN;
        end
        DRAIN: if (!rk_valid || (rk_ready && !rk_last)) begin
          rk_valid <= 1'b1;
          rk_data <= drain_key;
          rk_idx <= drain_idx;
          rk_last <= drain_idx == 4'd0;
        end
        default: if (wr_en) begin
          // COPY rotates the loaded key through the window; GEN shifts in the new word
          for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
          win[NK-1] <= new_w;
          i <= i + 6'd1;
          m <= m_nxt;
          if (state == GEN && m == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (completes) begin
            for (int j = 0; j < 3; j++) kbuf[j] <= '0;
            if (!rev) begin
              rk_valid <= 1'b1;
              rk_data <= {kbuf[0], kbuf[1], kbuf[2], new_w};
              rk_idx <= i[5:2];
              rk_last <= i[5:2] == 4'(NR);
            end
          end else kbuf[i[1:0]] <= new_w;
          state <= last_w ? (rev ? DRAIN : GEN) : (state == COPY && i < 6'(NK - 1)) ? COPY : sub_nxt ? SUB : GEN;
        end
      endcase
    end
  end
endmodule
